// File: rtl/fpu_pipe_pkg.sv
// Shared types and helpers for the elastic FPU pipeline register.
// Holds the flush-mode enum, the counter width helper and the reset fill value.
package fpu_pipe_pkg;

  // How a flush affects a stage: nothing, valid bits only, or valid bits and data.
  typedef enum logic [1:0] {
    FLUSH_NONE  = 2'd0,
    FLUSH_VALID = 2'd1,
    FLUSH_ALL   = 2'd2
  } flush_mode_e;

  // Every bit of the default reset/flush data value.
  localparam bit PIPE_RST_FILL = 1'b0;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int clog2p1(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Translate the flush strobe into the per-stage action.
  function automatic flush_mode_e flush_mode_of(input logic flush, input bit flush_data);
    if (!flush) begin
      return FLUSH_NONE;
    end
    return flush_data ? FLUSH_ALL : FLUSH_VALID;
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// Valid/ready/data stream bundle used on both sides of the pipeline register.
// master drives valid and data, slave drives ready.
interface elastic_pipe_reg_if #(
  parameter int WIDTH = 32
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One stage of the elastic pipeline: a valid bit plus a data register.
// The stage moves when i_load is set; data is only captured from a valid source,
// so the data register never holds an invalid beat.
module pipe_stage_reg
  import fpu_pipe_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  flush_mode_e      i_flush_mode,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Valid bit: cleared by reset or any flush, otherwise follows the source when allowed to move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (i_flush_mode != FLUSH_NONE) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  // Data register: reloaded with RST_VAL on reset or a data flush, captures only valid beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= RST_VAL;
    end else if (i_flush_mode == FLUSH_ALL) begin
      r_data <= RST_VAL;
    end else if ((i_flush_mode == FLUSH_NONE) && i_load && i_valid) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Multi-stage elastic pipeline register with valid/ready handshake.
// Empty stages absorb beats even while the output is stalled (bubble collapsing),
// so up to DEPTH beats are buffered before back-pressure reaches the input.
// A synchronous flush kills every stage; the asynchronous active-low reset does the same at once.
module elastic_pipe_reg
  import fpu_pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{PIPE_RST_FILL}},
  parameter bit               FLUSH_DATA = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  elastic_pipe_reg_if.slave             in_if,
  elastic_pipe_reg_if.master            out_if,
  output logic [clog2p1(DEPTH)-1:0]     occupancy
);

  localparam int CW = clog2p1(DEPTH);

  genvar gi;

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_in_fire;
  logic             w_out_fire;
  flush_mode_e      w_flush_mode;
  logic [CW-1:0]    r_occ;

  // Ready chain: a stage may move if it is empty or the stage after it moves.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_if.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = ~w_v[i] | w_rdy[i+1];
    end
  end

  assign w_flush_mode = flush_mode_of(flush, FLUSH_DATA);
  assign in_if.ready  = w_rdy[0] & ~flush;
  assign w_in_fire    = in_if.valid & in_if.ready;
  assign w_out_fire   = out_if.valid & out_if.ready;

  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;

    if (gi == 0) begin : g_head
      // The head stage only sees a valid source on an accepted input beat.
      assign w_src_valid = w_in_fire;
      assign w_src_data  = in_if.data;
    end else begin : g_body
      assign w_src_valid = w_v[gi-1];
      assign w_src_data  = w_d[gi-1];
    end

    pipe_stage_reg #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .i_flush_mode(w_flush_mode),
      .i_load      (w_rdy[gi]),
      .i_valid     (w_src_valid),
      .i_data      (w_src_data),
      .o_valid     (w_v[gi]),
      .o_data      (w_d[gi])
    );
  end

  assign out_if.valid = w_v[DEPTH-1];
  assign out_if.data  = w_d[DEPTH-1];

  // Occupancy tracks accepted minus delivered beats; a flush empties the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CW'(w_in_fire) - CW'(w_out_fire);
    end
  end

  assign occupancy = r_occ;

  a_occ_matches_valids : assert property (
    @(posedge clk) disable iff (!reset)
    32'(occupancy) == $countones(w_v)
  );

  a_out_stable_when_stalled : assert property (
    @(posedge clk) disable iff (!reset || flush)
    (out_if.valid && !out_if.ready) |=> (out_if.valid && $stable(out_if.data))
  );

  a_no_accept_on_flush : assert property (
    @(posedge clk) disable iff (!reset)
    flush |-> !in_if.ready
  );

endmodule
